// File: rtl/rat_pipe_pkg.sv
// Shared types for the RAT pipeline hazard controller: FSM states and the
// shape of an EX/WB destination shadow slot.
package rat_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic [REG_ADDR_W-1:0] addr;
        logic                  flg_wr;
    } hz_slot_t;

endpackage

// File: rtl/hz_slot_pipe.sv
// Shadows the destinations of the instructions in EX and WB and flags RAW
// hazards of the ID instruction against them (register file has no bypass).
module hz_slot_pipe #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_rx_used,
    input  logic                  id_ry_used,
    input  logic [REG_ADDR_W-1:0] id_rx_addr,
    input  logic [REG_ADDR_W-1:0] id_ry_addr,
    input  logic                  id_rf_wr,
    input  logic                  id_flg_rd,
    input  logic                  id_flg_wr,
    input  logic                  load_empty,
    output logic                  hazard,
    output logic                  slots_empty
);

    logic                  ex_valid, ex_wr, ex_flg_wr;
    logic [REG_ADDR_W-1:0] ex_addr;
    logic                  wb_valid, wb_wr, wb_flg_wr;
    logic [REG_ADDR_W-1:0] wb_addr;

    function automatic logic slot_hit(
        input logic                  s_valid,
        input logic                  s_wr,
        input logic [REG_ADDR_W-1:0] s_addr,
        input logic                  s_flg_wr,
        input logic                  rx_used,
        input logic [REG_ADDR_W-1:0] rx_addr,
        input logic                  ry_used,
        input logic [REG_ADDR_W-1:0] ry_addr,
        input logic                  flg_rd
    );
        return s_valid && ((rx_used && s_wr && (s_addr == rx_addr)) ||
                           (ry_used && s_wr && (s_addr == ry_addr)) ||
                           (flg_rd && s_flg_wr));
    endfunction

    // Address fields are only meaningful while the slot is valid, so they skip reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_wr     <= 1'b0;
            ex_flg_wr <= 1'b0;
            wb_valid  <= 1'b0;
            wb_wr     <= 1'b0;
            wb_flg_wr <= 1'b0;
        end else begin
            wb_valid  <= ex_valid;
            wb_wr     <= ex_wr;
            wb_flg_wr <= ex_flg_wr;
            if (load_empty) begin
                ex_valid  <= 1'b0;
                ex_wr     <= 1'b0;
                ex_flg_wr <= 1'b0;
            end else begin
                ex_valid  <= id_valid;
                ex_wr     <= id_rf_wr;
                ex_flg_wr <= id_flg_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        wb_addr <= ex_addr;
        ex_addr <= id_rx_addr;
    end

    assign hazard = id_valid &&
        (slot_hit(ex_valid, ex_wr, ex_addr, ex_flg_wr, id_rx_used, id_rx_addr,
                  id_ry_used, id_ry_addr, id_flg_rd) ||
         slot_hit(wb_valid, wb_wr, wb_addr, wb_flg_wr, id_rx_used, id_rx_addr,
                  id_ry_used, id_ry_addr, id_flg_rd));

    assign slots_empty = !ex_valid && !wb_valid;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / redirect / interrupt-entry sequencer for the RAT pipeline's PC,
// IF/ID and ID/EX registers, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic                   id_rx_used,
    input  logic                   id_ry_used,
    input  logic [REG_ADDR_W-1:0]  id_rx_addr,
    input  logic [REG_ADDR_W-1:0]  id_ry_addr,
    input  logic                   id_rf_wr,
    input  logic                   id_flg_rd,
    input  logic                   id_flg_wr,
    input  logic                   ex_branch_taken,
    input  logic                   intr_req,
    input  logic                   intr_en,
    output logic                   pc_hold,
    output logic                   ifid_hold,
    output logic                   ifid_flush,
    output logic                   idex_nop,
    output logic                   intr_ack,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    import rat_pipe_pkg::*;

    hz_state_t state;
    logic      hazard;
    logic      slots_empty;

    hz_slot_pipe #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_slots (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rx_used (id_rx_used),
        .id_ry_used (id_ry_used),
        .id_rx_addr (id_rx_addr),
        .id_ry_addr (id_ry_addr),
        .id_rf_wr   (id_rf_wr),
        .id_flg_rd  (id_flg_rd),
        .id_flg_wr  (id_flg_wr),
        .load_empty (idex_nop),
        .hazard     (hazard),
        .slots_empty(slots_empty)
    );

    // A taken branch wins over any stall; an ACK coinciding with it still takes the vector.
    always_comb begin
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_nop   = 1'b0;
        intr_ack   = 1'b0;
        if (rst) begin
            ifid_flush = 1'b1;
            idex_nop   = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_nop   = 1'b1;
            intr_ack   = (state == ACK);
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        pc_hold   = 1'b1;
                        ifid_hold = 1'b1;
                        idex_nop  = 1'b1;
                    end
                end
                DRAIN: begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                    idex_nop  = 1'b1;
                end
                ACK: begin
                    intr_ack   = 1'b1;
                    ifid_flush = 1'b1;
                    idex_nop   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            stall_cycles <= '0;
        end else begin
            if (pc_hold && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            end
            case (state)
                RUN:     if (intr_req && intr_en) state <= DRAIN;
                DRAIN:   if (slots_empty) state <= ACK;
                ACK:     state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised and directed bench for pipeline_hazard_ctrl against a
// queue-based behavioural model of the pipeline occupancy and interrupt entry.
module tb_pipeline_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 10;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rx_used, id_ry_used, id_rf_wr, id_flg_rd, id_flg_wr;
    logic [AW-1:0] id_rx_addr, id_ry_addr;
    logic          ex_branch_taken, intr_req, intr_en;
    logic          pc_hold, ifid_hold, ifid_flush, idex_nop, intr_ack;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (AW),
        .STALL_CNT_W(CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rx_used     (id_rx_used),
        .id_ry_used     (id_ry_used),
        .id_rx_addr     (id_rx_addr),
        .id_ry_addr     (id_ry_addr),
        .id_rf_wr       (id_rf_wr),
        .id_flg_rd      (id_flg_rd),
        .id_flg_wr      (id_flg_wr),
        .ex_branch_taken(ex_branch_taken),
        .intr_req       (intr_req),
        .intr_en        (intr_en),
        .pc_hold        (pc_hold),
        .ifid_hold      (ifid_hold),
        .ifid_flush     (ifid_flush),
        .idex_nop       (idex_nop),
        .intr_ack       (intr_ack),
        .stall_cycles   (stall_cycles)
    );

    typedef struct {
        bit v;
        bit w;
        int a;
        bit f;
    } rec_t;

    // Instructions that left ID, newest first: [0] is in EX, [1] is in WB.
    rec_t issued[$];
    bit   entering;     // interrupt accepted, waiting for the pipe to empty
    bit   vectoring;    // vector is taken this cycle
    int   cnt_m;

    int checks = 0;
    int passes = 0;
    bit o_hold, o_flush, o_nop, o_ack;
    int o_stall;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input bit r, input bit v, input bit rxu, input bit ryu,
                        input int rx, input int ry, input bit rfw, input bit fr,
                        input bit fw, input bit br, input bit ir, input bit ie);
        bit hz, empty, e_hold, e_flush, e_nop, e_ack;
        rec_t nr;
        @(negedge clk);
        rst = r; id_valid = v; id_rx_used = rxu; id_ry_used = ryu;
        id_rx_addr = AW'(rx); id_ry_addr = AW'(ry); id_rf_wr = rfw;
        id_flg_rd = fr; id_flg_wr = fw; ex_branch_taken = br;
        intr_req = ir; intr_en = ie;
        #1;
        hz = 1'b0;
        empty = 1'b1;
        foreach (issued[k]) begin
            if (issued[k].v) begin
                empty = 1'b0;
                if ((rxu && issued[k].w && issued[k].a == rx) ||
                    (ryu && issued[k].w && issued[k].a == ry) ||
                    (fr && issued[k].f)) hz = 1'b1;
            end
        end
        hz = hz && v;
        e_hold = 0; e_flush = 0; e_nop = 0; e_ack = 0;
        if (r) begin
            e_flush = 1; e_nop = 1;
        end else if (br) begin
            e_flush = 1; e_nop = 1; e_ack = vectoring;
        end else if (vectoring) begin
            e_ack = 1; e_flush = 1; e_nop = 1;
        end else if (entering || hz) begin
            e_hold = 1; e_nop = 1;
        end
        chk("pc_hold", pc_hold, e_hold);
        chk("ifid_hold", ifid_hold, e_hold);
        chk("ifid_flush", ifid_flush, e_flush);
        chk("idex_nop", idex_nop, e_nop);
        chk("intr_ack", intr_ack, e_ack);
        chk("stall_cycles", int'(stall_cycles), cnt_m);
        o_hold = pc_hold; o_flush = ifid_flush; o_nop = idex_nop;
        o_ack = intr_ack; o_stall = int'(stall_cycles);
        if (r) begin
            issued.delete();
            entering = 0; vectoring = 0; cnt_m = 0;
        end else begin
            if (e_hold && cnt_m < CNT_MAX) cnt_m++;
            if (vectoring) begin
                vectoring = 0;
            end else if (entering) begin
                if (empty) begin entering = 0; vectoring = 1; end
            end else if (ir && ie) begin
                entering = 1;
            end
            nr = e_nop ? '{0, 0, 0, 0} : '{v, rfw, rx, fw};
            issued.push_front(nr);
            if (issued.size() > 2) void'(issued.pop_back());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        entering = 0; vectoring = 0; cnt_m = 0;

        // Reset: flush and nop asserted, everything else quiet.
        step(1, 1, 1, 1, 3, 3, 1, 1, 1, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_nop", o_nop, 1);
        chk("rst_flush", o_flush, 1);
        chk("rst_hold", o_hold, 0);
        chk("rst_stall", o_stall, 0);

        // ADD r3 ; ADD r4,r3 -> two stall cycles.
        step(0, 1, 1, 1, 3, 1, 1, 0, 1, 0, 0, 0);
        chk("add_r3_hold", o_hold, 0);
        step(0, 1, 1, 1, 4, 3, 1, 0, 1, 0, 0, 0);
        chk("raw_ex_hold1", o_hold, 1);
        step(0, 1, 1, 1, 4, 3, 1, 0, 1, 0, 0, 0);
        chk("raw_ex_hold2", o_hold, 1);
        step(0, 1, 1, 1, 4, 3, 1, 0, 1, 0, 0, 0);
        chk("raw_ex_release", o_hold, 0);
        chk("raw_ex_count", o_stall, 2);
        idle(2);

        // ADD r5 ; MOV r6 ; OR r7,r5 -> one stall on the OR.
        step(0, 1, 1, 0, 5, 0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 6, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 7, 5, 1, 0, 1, 0, 0, 0);
        chk("raw_wb_hold", o_hold, 1);
        step(0, 1, 1, 1, 7, 5, 1, 0, 1, 0, 0, 0);
        chk("raw_wb_release", o_hold, 0);
        // A writer marked not-valid must not stall its reader.
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("invalid_writer", o_hold, 0);
        idle(2);

        // Taken branch while a RAW hazard exists.
        step(0, 1, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 9, 2, 1, 0, 0, 1, 0, 0);
        chk("br_flush", o_flush, 1);
        chk("br_nop", o_nop, 1);
        chk("br_hold", o_hold, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_after_hold", o_hold, 0);
        idle(2);

        // Interrupt with EX and WB full: two DRAIN cycles then one ack.
        step(0, 1, 1, 0, 8, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 9, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("intr_req_ack", o_ack, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("drain1_hold", o_hold, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("drain2_hold", o_hold, 1);
        chk("drain2_ack", o_ack, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ack_pulse", o_ack, 1);
        chk("ack_hold", o_hold, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ack_done", o_ack, 0);

        // Interrupts disabled: no ack, no drain.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk("masked_ack", o_ack, 0);
        end

        // Reset in DRAIN abandons the entry.
        step(0, 1, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_drain", o_hold, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_ack", o_ack, 0);
        chk("post_rst_hold", o_hold, 0);
        chk("post_rst_stall", o_stall, 0);
        idle(3);

        // Saturation: one stall per writer/reader pair.
        for (int i = 0; i < CNT_MAX + 80; i++) begin
            step(0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
            step(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_value", o_stall, CNT_MAX);

        // Random traffic on a small register window so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), $urandom_range(1), $urandom_range(1),
                 $urandom_range(1), $urandom_range(3), $urandom_range(3),
                 $urandom_range(1), ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(9) == 0), ($urandom_range(7) == 0), $urandom_range(1));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
